// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Two-requester round-robin arbiter for a shared 3-cycle real/complex
//            multiplier. Optional perf counters under MULT_ARBITER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_cplx,
   input  logic [63:0] req_ra,
   input  logic [63:0] req_rb,
   input  logic [63:0] req_ia,
   input  logic [63:0] req_ib,
   output logic [1:0]  req_gnt,
   output logic        mult_cplx,
   output logic [31:0] mult_ra,
   output logic [31:0] mult_rb,
   output logic [31:0] mult_ia,
   output logic [31:0] mult_ib,
   input  logic [63:0] mult_out,
   output logic        res_valid,
   output logic        res_id,
   output logic [63:0] res_data,
   output logic        busy
`ifdef MULT_ARBITER_PERF_EN
   ,
   output logic [15:0] op_cnt,
   output logic [15:0] bubble_cnt
`endif
);

   logic       ptr;
   logic       last_xfer;
   logic       last_id;
   logic [2:0] tag_vld;
   logic [2:0] tag_id;

   logic       winner;
   logic       win_vld;
   logic       win_cplx;
   logic       bubble;
   logic       xfer;

   always_comb begin
      win_vld  = |req_valid;
      winner   = (req_valid == 2'b11) ? ptr : req_valid[1];
      win_cplx = winner ? req_cplx[1] : req_cplx[0];
      // Multiplier stage 2 reads mult_cplx live, so a mode switch directly
      // behind a transfer would corrupt that transfer's result.
      bubble   = win_vld & last_xfer & (win_cplx != mult_cplx);
      req_gnt  = 2'b00;
      if (reset && win_vld && !bubble) begin
         req_gnt = winner ? 2'b10 : 2'b01;
      end
      xfer     = |req_gnt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= 1'b0;
         last_xfer <= 1'b0;
         last_id   <= 1'b0;
         tag_vld   <= 3'b000;
         tag_id    <= 3'b000;
         mult_cplx <= 1'b0;
         mult_ra   <= 32'd0;
         mult_rb   <= 32'd0;
         mult_ia   <= 32'd0;
         mult_ib   <= 32'd0;
      end else begin
         last_xfer <= xfer;
         last_id   <= winner;
         tag_vld   <= {tag_vld[1:0], last_xfer};
         tag_id    <= {tag_id[1:0], last_id};
         if (xfer) begin
            ptr       <= ~winner;
            mult_cplx <= win_cplx;
            mult_ra   <= winner ? req_ra[63:32] : req_ra[31:0];
            mult_rb   <= winner ? req_rb[63:32] : req_rb[31:0];
            mult_ia   <= winner ? req_ia[63:32] : req_ia[31:0];
            mult_ib   <= winner ? req_ib[63:32] : req_ib[31:0];
         end else begin
            mult_ra   <= 32'd0;
            mult_rb   <= 32'd0;
            mult_ia   <= 32'd0;
            mult_ib   <= 32'd0;
         end
      end
   end

   // last_xfer is the launch stage alongside the operand registers; the tag
   // then follows the three multiplier stages so it lines up with mult_out.
   assign res_valid = tag_vld[2];
   assign res_id    = tag_id[2];
   assign res_data  = mult_out;
   assign busy      = last_xfer | (|tag_vld);

`ifdef MULT_ARBITER_PERF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_cnt     <= 16'd0;
         bubble_cnt <= 16'd0;
      end else begin
         if (xfer) begin
            op_cnt <= op_cnt + 16'd1;
         end
         if (bubble) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench for mult_arbiter with a behavioural 3-stage
//            multiplier; perf checks enabled by MULT_ARBITER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_cplx;
   logic [63:0] req_ra, req_rb, req_ia, req_ib;
   logic [1:0]  req_gnt;
   logic        mult_cplx;
   logic [31:0] mult_ra, mult_rb, mult_ia, mult_ib;
   logic [63:0] mult_out;
   logic        res_valid, res_id;
   logic [63:0] res_data;
   logic        busy;
`ifdef MULT_ARBITER_PERF_EN
   logic [15:0] op_cnt, bubble_cnt;
`endif

   int nchk  = 0;
   int nfail = 0;

   always #5 clock = ~clock;

   mult_arbiter dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_cplx(req_cplx),
      .req_ra(req_ra), .req_rb(req_rb), .req_ia(req_ia), .req_ib(req_ib),
      .req_gnt(req_gnt), .mult_cplx(mult_cplx),
      .mult_ra(mult_ra), .mult_rb(mult_rb), .mult_ia(mult_ia), .mult_ib(mult_ib),
      .mult_out(mult_out), .res_valid(res_valid), .res_id(res_id),
      .res_data(res_data), .busy(busy)
`ifdef MULT_ARBITER_PERF_EN
      , .op_cnt(op_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // Behavioural multiplier: Q32 products, stage 2 samples mult_cplx live.
   logic [127:0] s1 = '0;
   logic [63:0]  s2 = '0;
   logic [63:0]  s3 = '0;

   function automatic logic [63:0] mul(input logic [127:0] op, input logic c);
      logic [31:0] ra, rb, ia, ib;
      logic [63:0] rr, ii, ri, ir, re, im;
      {ra, rb, ia, ib} = op;
      rr = {32'd0, ra} * {32'd0, rb};
      ii = {32'd0, ia} * {32'd0, ib};
      ri = {32'd0, ra} * {32'd0, ib};
      ir = {32'd0, ia} * {32'd0, rb};
      if (c) begin
         re = rr - ii;
         im = ri + ir;
      end else begin
         re = rr;
         im = ii;
      end
      return {re[63:32], im[63:32]};
   endfunction

   always @(posedge clock) begin
      s1 <= {mult_ra, mult_rb, mult_ia, mult_ib};
      s2 <= mul(s1, mult_cplx);
      s3 <= s2;
   end
   assign mult_out = s3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  cplx;
      logic [1:0]  gnt;
      logic        rv;
      logic        rid;
      logic [63:0] rdata;
   } vec_t;

   localparam logic [63:0] D0  = 64'h00000002_00000000; // req0, either mode
   localparam logic [63:0] D1R = 64'h00000003_00000002; // req1 real pair
   localparam logic [63:0] D1C = 64'h00000001_00000007; // req1 complex
   localparam int NV = 23;
   vec_t vec [NV];

   initial begin
      // Stream of 4 same-mode ops, solo op, bubble case, idle-then-mode-change.
      vec[0]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 64'h0};
      vec[1]  = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 64'h0};
      vec[2]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 64'h0};
      vec[3]  = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 64'h0};
      vec[4]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, D0};
      vec[5]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, D1R};
      vec[6]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, D0};
      vec[7]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, D1R};
      vec[8]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 64'h0};
      vec[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[10] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[12] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, D0};
      vec[13] = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 64'h0};
      vec[14] = '{2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[15] = '{2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 64'h0};
      vec[16] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[17] = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0, D0};
      vec[18] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[19] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, D1C};
      vec[20] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vec[21] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, D0};
      vec[22] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};

      req_ra    = {32'h00010000, 32'h00010000};
      req_rb    = {32'h00030000, 32'h00020000};
      req_ia    = {32'h00020000, 32'h00000000};
      req_ib    = {32'h00010000, 32'h00000000};
      req_valid = 2'b11;
      req_cplx  = 2'b00;
      reset     = 1'b0;
      #1;
      chk("rst_gnt", 64'(req_gnt), 64'h0);
      chk("rst_res_valid", 64'(res_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_mult_cplx", 64'(mult_cplx), 64'h0);
      chk("rst_mult_rb", 64'(mult_rb), 64'h0);
      repeat (3) @(negedge clock);
      req_valid = 2'b00;
      reset     = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         req_valid = vec[i].valid;
         req_cplx  = vec[i].cplx;
         #1;
         chk($sformatf("gnt[%0d]", i), 64'(req_gnt), 64'(vec[i].gnt));
         chk($sformatf("res_valid[%0d]", i), 64'(res_valid), 64'(vec[i].rv));
         if (vec[i].rv) begin
            chk($sformatf("res_id[%0d]", i), 64'(res_id), 64'(vec[i].rid));
            chk($sformatf("res_data[%0d]", i), res_data, vec[i].rdata);
         end
      end

`ifdef MULT_ARBITER_PERF_EN
      chk("op_cnt_table", 64'(op_cnt), 64'd8);
      chk("bubble_cnt_table", 64'(bubble_cnt), 64'd1);
`endif

      // Two ops in flight, then reset mid-cycle.
      @(negedge clock);
      req_valid = 2'b11;
      req_cplx  = 2'b00;
      #1;
      chk("pre_rst_gnt_a", 64'(req_gnt), 64'h2);
      chk("idle_operand_zero", 64'(mult_rb), 64'h0);
      @(negedge clock);
      #1;
      chk("pre_rst_gnt_b", 64'(req_gnt), 64'h1);
      chk("busy_in_flight", 64'(busy), 64'h1);
      chk("operand_req1", 64'(mult_rb), 64'h00030000);
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_res_valid", 64'(res_valid), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_gnt", 64'(req_gnt), 64'h0);
      chk("mid_rst_mult_rb", 64'(mult_rb), 64'h0);
      @(negedge clock);
      #1;
      chk("held_rst_gnt", 64'(req_gnt), 64'h0);
      chk("held_rst_res_valid", 64'(res_valid), 64'h0);
      reset     = 1'b1;
      req_valid = 2'b00;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         #1;
         chk($sformatf("post_rst_no_res[%0d]", k), 64'(res_valid), 64'h0);
      end

      // Pointer restarts at requester 0 after reset.
      @(negedge clock);
      req_valid = 2'b11;
      #1;
      chk("post_rst_ptr", 64'(req_gnt), 64'h1);
      @(negedge clock);
      req_valid = 2'b00;
      repeat (2) @(negedge clock);
      #1;
      chk("post_rst_lat3_no_res", 64'(res_valid), 64'h0);
      @(negedge clock);
      #1;
      chk("post_rst_res_valid", 64'(res_valid), 64'h1);
      chk("post_rst_res_id", 64'(res_id), 64'h0);
      chk("post_rst_res_data", res_data, D0);

`ifdef MULT_ARBITER_PERF_EN
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("perf_rst_op_cnt", 64'(op_cnt), 64'h0);
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 2'b01;
      repeat (65537) @(posedge clock);
      @(negedge clock);
      req_valid = 2'b00;
      #1;
      chk("op_cnt_wrap", 64'(op_cnt), 64'h1);
      chk("bubble_cnt_wrap_run", 64'(bubble_cnt), 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
`default_nettype wire
